// File: rtl/aes_round_ctrl.sv
// Round sequencer for the AES-128 datapath and key expansion: walks counter_t
// through 1..NROUNDS+1, issuing one round_en per round and one key_step per key.
module aes_round_ctrl #(
    parameter int unsigned NROUNDS = 10,
    parameter int unsigned KEY_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic [3:0] counter_t,
    output logic       round_en,
    output logic       first_round,
    output logic       mix_en,
    output logic       key_step,
    output logic       busy,
    output logic       done,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NROUNDS + 1);
    localparam logic [3:0] NR         = 4'(NROUNDS);
    localparam logic [2:0] WAIT_INIT  = 3'(KEY_LAT - 1);

    state_t     state, state_n;
    logic [3:0] count_n;
    logic [2:0] wait_cnt, wait_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            counter_t <= 4'd0;
            wait_cnt  <= 3'd0;
        end else begin
            state     <= state_n;
            counter_t <= count_n;
            wait_cnt  <= wait_n;
        end
    end

    always_comb begin
        state_n = state;
        count_n = counter_t;
        wait_n  = wait_cnt;
        case (state)
            IDLE: begin
                count_n = 4'd0;
                if (start && !abort) begin
                    state_n = RUN;
                    count_n = 4'd1;
                end
            end
            RUN: begin
                state_n = WAIT;
                wait_n  = WAIT_INIT;
            end
            WAIT: begin
                if (wait_cnt == 3'd0) begin
                    if (counter_t == LAST_ROUND) begin
                        state_n = DONE;
                    end else begin
                        state_n = RUN;
                        count_n = counter_t + 4'd1;
                    end
                end else begin
                    wait_n = wait_cnt - 3'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
                count_n = 4'd0;
            end
            default: begin
                state_n = IDLE;
                count_n = 4'd0;
            end
        endcase
        // Abort wins over every in-flight transition; outputs of this cycle stay as computed.
        if (abort && state != IDLE) begin
            state_n = IDLE;
            count_n = 4'd0;
            wait_n  = 3'd0;
        end
    end

    always_comb begin
        round_en    = 1'b0;
        first_round = 1'b0;
        mix_en      = 1'b0;
        key_step    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            RUN: begin
                round_en    = 1'b1;
                busy        = 1'b1;
                first_round = (counter_t == 4'd1);
                mix_en      = (counter_t >= 4'd2) && (counter_t <= NR);
            end
            WAIT: begin
                busy     = 1'b1;
                // Only the first settle cycle steps the key; the final round needs no new key.
                key_step = (wait_cnt == WAIT_INIT) && (counter_t <= NR);
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: three parameterisations, per-cycle output
// vectors predicted from the round timing and compared from an expected queue.
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic       start [3];
    logic       abort [3];
    logic [3:0] ct    [3];
    logic       re    [3];
    logic       fr    [3];
    logic       me    [3];
    logic       ks    [3];
    logic       bz    [3];
    logic       dn    [3];
    logic [1:0] sd    [3];
    logic [9:0] out_v [3];

    logic [9:0] exp_q[$];
    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    // Instance 0: defaults; instance 1: KEY_LAT=3; instance 2: NROUNDS=1.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_round_ctrl #(
            .NROUNDS((g == 2) ? 1 : 10),
            .KEY_LAT((g == 1) ? 3 : 1)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start[g]),
            .abort       (abort[g]),
            .counter_t   (ct[g]),
            .round_en    (re[g]),
            .first_round (fr[g]),
            .mix_en      (me[g]),
            .key_step    (ks[g]),
            .busy        (bz[g]),
            .done        (dn[g]),
            .state_dbg   (sd[g])
        );
        assign out_v[g] = {ct[g], re[g], fr[g], me[g], ks[g], bz[g], dn[g]};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Vector layout: {counter_t, round_en, first_round, mix_en, key_step, busy, done}.
    function automatic logic [9:0] mk(input int c, input bit r, input bit f, input bit m,
                                      input bit k, input bit b, input bit d);
        mk = {4'(c), r, f, m, k, b, d};
    endfunction

    task automatic push_run(input int r, input int nr);
        exp_q.push_back(mk(r, 1'b1, r == 1, (r >= 2) && (r <= nr), 1'b0, 1'b1, 1'b0));
    endtask

    task automatic push_round(input int r, input int nr, input int kl);
        push_run(r, nr);
        for (int w = 0; w < kl; w++)
            exp_q.push_back(mk(r, 1'b0, 1'b0, 1'b0, (w == 0) && (r <= nr), 1'b1, 1'b0));
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(10'd0);
    endtask

    task automatic push_op(input int nr, input int kl);
        for (int r = 1; r <= nr + 1; r++) push_round(r, nr, kl);
        exp_q.push_back(mk(nr + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        push_idle(1);
    endtask

    task automatic check(input int inst, input string tag);
        logic [9:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            $error("FAIL %s: expected queue empty, observed=%h", tag, out_v[inst]);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        assert (out_v[inst] === e) passes++;
        else $error("FAIL %s inst%0d: observed=%h expected=%h", tag, inst, out_v[inst], e);
    endtask

    // Drains the whole queue against one instance; start drops after the first edge unless held.
    task automatic drain(input int inst, input bit hold, input string tag);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            step();
            if (!hold) start[inst] = 1'b0;
            check(inst, tag);
        end
    endtask

    task automatic run_op(input int inst, input int nr, input int kl, input bit hold,
                          input string tag);
        push_op(nr, kl);
        start[inst] = 1'b1;
        drain(inst, hold, tag);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            abort[i] = 1'b0;
        end
        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_idle(1);
            check(i, "reset");
        end

        // Nominal run with defaults: done 23 cycles after start.
        run_op(0, 10, 1, 1'b0, "nominal");
        // Longer key settle time: round_en every 4 cycles, done at 45.
        run_op(1, 10, 3, 1'b0, "key_lat3");
        // Minimal cipher: two rounds, done at 5.
        run_op(2, 1, 1, 1'b0, "nr1");

        // Abort during the WAIT of round 5.
        for (int r = 1; r <= 5; r++) push_round(r, 10, 1);
        start[0] = 1'b1;
        drain(0, 1'b0, "abort_pre");
        abort[0] = 1'b1;
        push_idle(3);
        step();
        abort[0] = 1'b0;
        check(0, "abort_idle");
        drain(0, 1'b0, "abort_quiet");
        run_op(0, 10, 1, 1'b0, "after_abort");

        // Reset during the RUN of round 7.
        for (int r = 1; r <= 6; r++) push_round(r, 10, 1);
        push_run(7, 10);
        start[0] = 1'b1;
        drain(0, 1'b0, "rst_pre");
        rst = 1'b1;
        push_idle(3);
        step();
        rst = 1'b0;
        check(0, "rst_idle");
        drain(0, 1'b0, "rst_quiet");
        run_op(0, 10, 1, 1'b0, "after_rst");

        // Start held high: one op per done, next RUN two cycles after done.
        run_op(0, 10, 1, 1'b1, "held_first");
        run_op(0, 10, 1, 1'b0, "held_second");

        // Start and abort together in IDLE: nothing happens.
        start[0] = 1'b1;
        abort[0] = 1'b1;
        push_idle(3);
        drain(0, 1'b1, "start_abort");
        start[0] = 1'b0;
        abort[0] = 1'b0;
        push_idle(2);
        drain(0, 1'b0, "quiet_end");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
